// File: rtl/hc_arith_pkg.sv
// ----------------------------------------------------------------------------
// hc_arith_pkg
// Shared constants and the stage-1 pipeline register layout for the
// Han-Carlson prefix arithmetic blocks.
//
// Optional feature macro: HCSUB_OVF_EN. When it is defined, the operand sign
// bits are carried in the stage-1 register so that signed overflow can be
// formed at the output stage.
// ----------------------------------------------------------------------------
package hc_arith_pkg;

    localparam int HC_WIDTH     = 30;
    localparam int HC_LEVELS    = 5;            // spans 2, 4, 8, 16, 32
    localparam int HC_S1_LEVELS = 3;            // levels finished before the S1 register
    localparam int HC_ODD       = HC_WIDTH / 2; // odd bit positions 1, 3, ..., 29

    // Stage-1 register. og/op index k stands for bit position 2k+1 and hold
    // the group generate/propagate after HC_S1_LEVELS levels.
    typedef struct packed {
        logic [HC_WIDTH-1:0] p;
        logic [HC_WIDTH-1:0] g;
        logic [HC_ODD-1:0]   og;
        logic [HC_ODD-1:0]   op;
`ifdef HCSUB_OVF_EN
        logic                a_msb;
        logic                b_msb;
`endif
        logic                cin;
    } hc_s1_t;

endpackage

// File: rtl/hc_pg_cell.sv
// ----------------------------------------------------------------------------
// hc_pg_cell
// Prefix combine cell. Black cell by default; with GREY = 1 the lower operand
// is already a group prefix, so only the generate is needed and o_p is tied 0.
//
// Ports:
//   i_g_hi, i_p_hi : generate/propagate of the more significant span
//   i_g_lo, i_p_lo : generate/propagate of the less significant span
//   o_g, o_p       : combined generate/propagate (o_p = 0 for grey cells)
// ----------------------------------------------------------------------------
module hc_pg_cell #(
    parameter bit GREY = 1'b0
) (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);

    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = GREY ? 1'b0 : (i_p_hi & i_p_lo);

endmodule

// File: rtl/hc_sub_pipe.sv
// ----------------------------------------------------------------------------
// hc_sub_pipe
// Two-stage pipelined 30-bit Han-Carlson subtractor: diff = a - b - bin,
// computed as a + ~b + ~bin. Stage S1 runs pre-compute and prefix levels
// 1-3 on odd positions; stage S2 runs levels 4-5, the even-position grey
// fix-up, the sum XOR and the borrow-out.
//
// Optional feature macro: HCSUB_OVF_EN (adds the ovf output, signed overflow).
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/ out_ready: result handshake (diff, bout[, ovf])
//   diff                : (a - b - bin) mod 2^30, registered
//   bout                : 1 when a < b + bin (unsigned), registered
//   ovf                 : signed overflow, registered (HCSUB_OVF_EN only)
// ----------------------------------------------------------------------------
module hc_sub_pipe
    import hc_arith_pkg::*;
#(
    parameter int WIDTH = HC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef HCSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Handshake: a beat moves on a side when valid and ready are both high at
    // the rising edge. S2 advances when S1 holds a beat and S2 is empty or
    // being drained; S1 accepts when it is empty or emptying into S2, so
    // in_ready follows out_ready combinationally and a full stall releases
    // without a bubble.
    logic r_s1_v;
    logic r_s2_v;
    logic w_s2_adv;
    logic w_accept;

    assign w_s2_adv  = r_s1_v & (~r_s2_v | out_ready);
    assign in_ready  = ~r_s1_v | w_s2_adv;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_s2_v;

    // ---------------- Stage S1 ----------------
    logic [HC_WIDTH-1:0] w_p;
    logic [HC_WIDTH-1:0] w_g;
    logic                w_cin;
    logic                w_g0c;
    logic                w_unused_p0;
    logic [HC_ODD-1:0]   w_g_s1 [1:HC_S1_LEVELS];
    logic [HC_ODD-1:0]   w_p_s1 [1:HC_S1_LEVELS];
    hc_s1_t              w_s1;
    hc_s1_t              r_s1;

    assign w_p   = a ^ ~b;
    assign w_g   = a & ~b;
    assign w_cin = ~bin;

    // Bit 0 absorbs the carry-in so every later prefix starting at bit 0 is
    // already the carry into the next position.
    hc_pg_cell #(.GREY(1'b1)) u_bit0 (
        .i_g_hi(w_g[0]), .i_p_hi(w_p[0]), .i_g_lo(w_cin), .i_p_lo(1'b0),
        .o_g(w_g0c), .o_p(w_unused_p0)
    );

    // Level 1: each odd position combines with the even position below it.
    for (genvar k = 0; k < HC_ODD; k++) begin : g_l1
        if (k == 0) begin : g_grey
            hc_pg_cell #(.GREY(1'b1)) u_cell (
                .i_g_hi(w_g[1]), .i_p_hi(w_p[1]), .i_g_lo(w_g0c), .i_p_lo(1'b0),
                .o_g(w_g_s1[1][0]), .o_p(w_p_s1[1][0])
            );
        end else begin : g_black
            hc_pg_cell #(.GREY(1'b0)) u_cell (
                .i_g_hi(w_g[2*k+1]), .i_p_hi(w_p[2*k+1]),
                .i_g_lo(w_g[2*k]),   .i_p_lo(w_p[2*k]),
                .o_g(w_g_s1[1][k]), .o_p(w_p_s1[1][k])
            );
        end
    end

    // Levels 2..3 on odd positions. Distance D counts odd slots. Slots below
    // D are finished and pass through; slots below 2*D combine with a
    // finished prefix, so a grey cell is enough.
    for (genvar lvl = 2; lvl <= HC_S1_LEVELS; lvl++) begin : g_s1_lvl
        localparam int D = 1 << (lvl - 2);
        for (genvar k = 0; k < HC_ODD; k++) begin : g_k
            if (k < D) begin : g_pass
                assign w_g_s1[lvl][k] = w_g_s1[lvl-1][k];
                assign w_p_s1[lvl][k] = w_p_s1[lvl-1][k];
            end else begin : g_cell
                hc_pg_cell #(.GREY(k < 2*D)) u_cell (
                    .i_g_hi(w_g_s1[lvl-1][k]),   .i_p_hi(w_p_s1[lvl-1][k]),
                    .i_g_lo(w_g_s1[lvl-1][k-D]), .i_p_lo(w_p_s1[lvl-1][k-D]),
                    .o_g(w_g_s1[lvl][k]), .o_p(w_p_s1[lvl][k])
                );
            end
        end
    end

    always_comb begin
        w_s1     = '0;
        w_s1.p   = w_p;
        w_s1.g   = w_g;
        w_s1.og  = w_g_s1[HC_S1_LEVELS];
        w_s1.op  = w_p_s1[HC_S1_LEVELS];
        w_s1.cin = w_cin;
`ifdef HCSUB_OVF_EN
        w_s1.a_msb = a[HC_WIDTH-1];
        w_s1.b_msb = b[HC_WIDTH-1];
`endif
    end

    // Data only; validity is carried by r_s1_v.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1 <= w_s1;
        end
    end

    // ---------------- Stage S2 ----------------
    logic [HC_ODD-1:0]   w_g_s2 [HC_S1_LEVELS:HC_LEVELS];
    logic [HC_ODD-1:0]   w_p_s2 [HC_S1_LEVELS:HC_LEVELS];
    logic [HC_WIDTH-1:0] w_gpre;            // w_gpre[i] = G[i:0] including carry-in
    logic [HC_ODD-1:0]   w_unused_fix_p;
    logic [HC_WIDTH-1:0] w_sum;
    logic                w_bout;
    logic                w_unused_bits;

    assign w_g_s2[HC_S1_LEVELS] = r_s1.og;
    assign w_p_s2[HC_S1_LEVELS] = r_s1.op;

    for (genvar lvl = HC_S1_LEVELS + 1; lvl <= HC_LEVELS; lvl++) begin : g_s2_lvl
        localparam int D = 1 << (lvl - 2);
        for (genvar k = 0; k < HC_ODD; k++) begin : g_k
            if (k < D) begin : g_pass
                assign w_g_s2[lvl][k] = w_g_s2[lvl-1][k];
                assign w_p_s2[lvl][k] = w_p_s2[lvl-1][k];
            end else begin : g_cell
                hc_pg_cell #(.GREY(k < 2*D)) u_cell (
                    .i_g_hi(w_g_s2[lvl-1][k]),   .i_p_hi(w_p_s2[lvl-1][k]),
                    .i_g_lo(w_g_s2[lvl-1][k-D]), .i_p_lo(w_p_s2[lvl-1][k-D]),
                    .o_g(w_g_s2[lvl][k]), .o_p(w_p_s2[lvl][k])
                );
            end
        end
    end

    // Even-position fix-up: each even bit extends the finished prefix of the
    // odd bit just below it (bit 0 extends the carry-in).
    for (genvar k = 0; k < HC_ODD; k++) begin : g_fix
        assign w_gpre[2*k+1] = w_g_s2[HC_LEVELS][k];
        if (k == 0) begin : g_bit0
            hc_pg_cell #(.GREY(1'b1)) u_cell (
                .i_g_hi(r_s1.g[0]), .i_p_hi(r_s1.p[0]), .i_g_lo(r_s1.cin), .i_p_lo(1'b0),
                .o_g(w_gpre[0]), .o_p(w_unused_fix_p[0])
            );
        end else begin : g_even
            hc_pg_cell #(.GREY(1'b1)) u_cell (
                .i_g_hi(r_s1.g[2*k]), .i_p_hi(r_s1.p[2*k]),
                .i_g_lo(w_g_s2[HC_LEVELS][k-1]), .i_p_lo(1'b0),
                .o_g(w_gpre[2*k]), .o_p(w_unused_fix_p[k])
            );
        end
    end

    assign w_sum  = r_s1.p ^ {w_gpre[HC_WIDTH-2:0], r_s1.cin};
    assign w_bout = ~w_gpre[HC_WIDTH-1];   // borrow is the inverted carry-out

    // Odd-position g bits and the top-level P terms are not needed after the tree.
    assign w_unused_bits = ^{r_s1.g, w_p_s2[HC_LEVELS], w_unused_fix_p, w_unused_p0};

    logic [HC_WIDTH-1:0] r_diff;
    logic                r_bout;
`ifdef HCSUB_OVF_EN
    logic                r_ovf;
    logic                w_ovf;
    assign w_ovf = (r_s1.a_msb ^ r_s1.b_msb) & (w_sum[HC_WIDTH-1] ^ r_s1.a_msb);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
`ifdef HCSUB_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            r_s1_v <= w_accept | (r_s1_v & ~w_s2_adv);
            r_s2_v <= w_s2_adv | (r_s2_v & ~out_ready);
            if (w_s2_adv) begin
                r_diff <= w_sum;
                r_bout <= w_bout;
`ifdef HCSUB_OVF_EN
                r_ovf  <= w_ovf;
`endif
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
`ifdef HCSUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_hc_sub_pipe.sv
module tb_hc_sub_pipe;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] a;
  logic [29:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] diff;
  logic        bout;
`ifdef HCSUB_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  hc_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef HCSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  // Expected word: {ovf, bout, diff}.
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [29:0] ma, input logic [29:0] mb, input logic mbin);
    logic [30:0] r;
    logic        v;
    r = {1'b0, ma} - {1'b0, mb} - {30'd0, mbin};
    v = (ma[29] ^ mb[29]) & (r[29] ^ ma[29]);
    return {v, r};
  endfunction

  // Output monitor: a beat transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [31:0] e;
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", {2'b0, diff}, {2'b0, e[29:0]});
        check("bout", {31'd0, bout}, {31'd0, e[30]});
`ifdef HCSUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e[31]});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [29:0] ta, input logic [29:0] tb, input logic tbin,
                           input logic [31:0] texp);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    while (!done) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta; b = tb; bin = tbin;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(texp);
        n_in++;
        done = 1;
      end else if (++waited > 50) begin
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drain(input int limit);
    int c;
    c = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int cyc;
    logic [29:0] ra;
    logic [29:0] rb;
    logic        rbin;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 30'h1234567; b = 30'h0abcdef; bin = 1'b1;

    // Reset held 3 cycles with in_valid high.
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_diff", {2'b0, diff}, 32'd0);
      check("rst_bout", {31'd0, bout}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Latency: accept cycle k, output presented in cycle k+2.
    send_beat(30'h0000_0005, 30'h0000_0003, 1'b0, {1'b0, 1'b0, 30'd2});
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_out_valid", {31'd0, out_valid}, 32'd1);
    idle(2);

    // Borrow wrap and full carry chain.
    send_beat(30'h0000_0000, 30'h0000_0000, 1'b1, {1'b0, 1'b1, 30'h3FFF_FFFF});
    send_beat(30'h2000_0000, 30'h1FFF_FFFF, 1'b0, {1'b1, 1'b0, 30'h0000_0001});
    drain(10);

    // Backpressure: 4 beats offered with out_ready low, only 2 fit.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (idx < 4) begin
        in_valid = 1'b1; a = 30'h100 + 30'(idx); b = 30'(idx * 7); bin = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        n_in++;
        idx++;
      end
    end
    check("bp_accepted", idx, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    // Release: four results on four consecutive cycles, remaining beats enter.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (idx < 4) begin
        in_valid = 1'b1; a = 30'h100 + 30'(idx); b = 30'(idx * 7); bin = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_stream_out_valid", {31'd0, out_valid}, 32'd1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        n_in++;
        idx++;
      end
    end
    check("bp_all_accepted", idx, 32'd4);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained_out_valid", {31'd0, out_valid}, 32'd0);

    // Mid-flight reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(30'h0AAA_AAAA, 30'h0555_5555, 1'b0, model(30'h0AAA_AAAA, 30'h0555_5555, 1'b0));
    send_beat(30'h0000_0001, 30'h0000_0002, 1'b1, model(30'h0000_0001, 30'h0000_0002, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    n_in -= exp_q.size();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale_beat", {31'd0, out_valid}, 32'd0);
    end
    send_beat(30'h0000_1234, 30'h0000_0234, 1'b1, {1'b0, 1'b0, 30'h0000_0FFF});
    drain(10);

    // Random traffic with random in_valid / out_ready.
    idx = 0;
    cyc = 0;
    while (idx < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      case ($urandom_range(0, 7))
        0:       ra = 30'd0;
        1:       ra = 30'h3FFF_FFFF;
        default: ra = 30'($urandom());
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 30'd0;
        1:       rb = 30'h3FFF_FFFF;
        2:       rb = ra;
        default: rb = 30'($urandom());
      endcase
      rbin      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = ra; b = rb; bin = rbin;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ra, rb, rbin));
        n_in++;
        idx++;
      end
    end
    check("random_beats_sent", idx, 32'd10000);
    drain(20);
    check("beat_count", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
